// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 2R1W register file: round-robin merge of ALU and LSU
// writebacks onto one registered write port, with forwarding of the in-flight write.
module rf_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATAWIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_stall,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATAWIDTH-1:0]  alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATAWIDTH-1:0]  lsu_data,
    output logic                  wr_reg_en,
    output logic [ADDR_WIDTH-1:0] wr_reg_addr,
    output logic [DATAWIDTH-1:0]  wr_wdata,
    input  logic [ADDR_WIDTH-1:0] fwd_addr1,
    input  logic [ADDR_WIDTH-1:0] fwd_addr2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [DATAWIDTH-1:0]  fwd_data1,
    output logic [DATAWIDTH-1:0]  fwd_data2
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    src_e                  last_grant_q;
    src_e                  last_grant_d;
    logic                  grant_alu;
    logic                  grant_lsu;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATAWIDTH-1:0]  wr_data_d;

    // Grant: a lone requester always wins; on a tie the source not granted last wins.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst && !wb_stall) begin
            if (alu_valid && lsu_valid) begin
                if (last_grant_q == SRC_LSU) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else if (alu_valid) begin
                grant_alu = 1'b1;
            end else if (lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;

    // Next write-port contents; an x0 destination completes the handshake but never writes.
    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_reg_addr;
        wr_data_d    = wr_wdata;
        if (grant_alu) begin
            last_grant_d = SRC_ALU;
            wr_en_d      = (alu_addr != ADDR_WIDTH'(0));
            wr_addr_d    = alu_addr;
            wr_data_d    = alu_data;
        end else if (grant_lsu) begin
            last_grant_d = SRC_LSU;
            wr_en_d      = (lsu_addr != ADDR_WIDTH'(0));
            wr_addr_d    = lsu_addr;
            wr_data_d    = lsu_data;
        end
    end

    // Reset leaves LSU as last grantee so the ALU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= SRC_LSU;
            wr_reg_en    <= 1'b0;
            wr_reg_addr  <= '0;
            wr_wdata     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_reg_en    <= wr_en_d;
            wr_reg_addr  <= wr_addr_d;
            wr_wdata     <= wr_data_d;
        end
    end

    // Forwarding covers the cycle before the register file holds the value.
    always_comb begin
        fwd_hit1  = wr_reg_en && (fwd_addr1 == wr_reg_addr) && (fwd_addr1 != ADDR_WIDTH'(0));
        fwd_hit2  = wr_reg_en && (fwd_addr2 == wr_reg_addr) && (fwd_addr2 != ADDR_WIDTH'(0));
        fwd_data1 = fwd_hit1 ? wr_wdata : DATAWIDTH'(0);
        fwd_data2 = fwd_hit2 ? wr_wdata : DATAWIDTH'(0);
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by randomized traffic, all
// checked against a cycle-level reference model of the writeback port.
module tb_rf_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          wb_stall;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_data;
    logic          wr_reg_en;
    logic [AW-1:0] wr_reg_addr;
    logic [DW-1:0] wr_wdata;
    logic [AW-1:0] fwd_addr1;
    logic [AW-1:0] fwd_addr2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .wb_stall(wb_stall),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .wr_reg_en(wr_reg_en), .wr_reg_addr(wr_reg_addr), .wr_wdata(wr_wdata),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who was served last, and what the write port should be showing.
    bit            m_lsu_last;
    bit            m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lsu_last = 1'b1;
        m_en       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
    endtask

    task automatic chk_fwd();
        bit h1, h2;
        h1 = m_en && (fwd_addr1 == m_addr) && (fwd_addr1 != 0);
        h2 = m_en && (fwd_addr2 == m_addr) && (fwd_addr2 != 0);
        chk("fwd_hit1", 32'(fwd_hit1), 32'(h1));
        chk("fwd_hit2", 32'(fwd_hit2), 32'(h2));
        chk("fwd_data1", fwd_data1, h1 ? m_data : 32'h0);
        chk("fwd_data2", fwd_data2, h2 ? m_data : 32'h0);
    endtask

    // One clock: check ready and forwarding mid-cycle, then the write port after the edge.
    task automatic step(output bit ga, output bit gl);
        int n_req;
        @(negedge clk);
        n_req = int'(alu_valid) + int'(lsu_valid);
        ga = 1'b0;
        gl = 1'b0;
        if (!wb_stall && n_req == 2) begin
            ga = m_lsu_last;
            gl = !m_lsu_last;
        end else if (!wb_stall && n_req == 1) begin
            ga = alu_valid;
            gl = lsu_valid;
        end
        chk("alu_ready", 32'(alu_ready), 32'(ga));
        chk("lsu_ready", 32'(lsu_ready), 32'(gl));
        chk_fwd();
        @(posedge clk);
        #1;
        m_en = 1'b0;
        if (ga || gl) begin
            m_lsu_last = gl;
            m_addr     = ga ? alu_addr : lsu_addr;
            m_data     = ga ? alu_data : lsu_data;
            m_en       = (m_addr != 0);
        end
        chk("wr_reg_en", 32'(wr_reg_en), 32'(m_en));
        if (m_en) begin
            chk("wr_reg_addr", 32'(wr_reg_addr), 32'(m_addr));
            chk("wr_wdata", wr_wdata, m_data);
        end
    endtask

    initial begin
        bit ga, gl;
        int ai, li;
        int exp_addr[4];

        rst = 1'b1; wb_stall = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h2;
        fwd_addr1 = '0; fwd_addr2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_alu", 32'(alu_ready), 32'h0);
        chk("rst_ready_lsu", 32'(lsu_ready), 32'h0);
        chk("rst_wr_en", 32'(wr_reg_en), 32'h0);
        chk("rst_wr_addr", 32'(wr_reg_addr), 32'h0);
        chk("rst_wr_data", wr_wdata, 32'h0);
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;

        // Single ALU write: visible the cycle after acceptance, enable drops when idle.
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        step(ga, gl);
        chk("single_grant", 32'(ga), 32'h1);
        alu_valid = 1'b0;
        chk("single_en", 32'(wr_reg_en), 32'h1);
        chk("single_addr", 32'(wr_reg_addr), 32'd5);
        chk("single_data", wr_wdata, 32'hDEADBEEF);
        step(ga, gl);
        chk("idle_en", 32'(wr_reg_en), 32'h0);
        chk("idle_hold_addr", 32'(wr_reg_addr), 32'd5);
        chk("idle_hold_data", wr_wdata, 32'hDEADBEEF);

        // Reset in the middle of an in-flight write discards it.
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        step(ga, gl);
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_en", 32'(wr_reg_en), 32'h0);
        chk("midrst_addr", 32'(wr_reg_addr), 32'h0);
        chk("midrst_data", wr_wdata, 32'h0);
        chk("midrst_ready", 32'(alu_ready), 32'h0);
        alu_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention: ALU wins the first tie after reset, then strict alternation.
        exp_addr = '{1, 9, 2, 10};
        ai = 0; li = 0;
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1'b1; alu_addr = AW'(1 + ai); alu_data = 32'(32'hA00 + ai);
            lsu_valid = 1'b1; lsu_addr = AW'(9 + li); lsu_data = 32'(32'hB00 + li);
            step(ga, gl);
            chk("contend_addr", 32'(wr_reg_addr), 32'(exp_addr[c]));
            if (ga) ai++;
            if (gl) li++;
        end

        // Stall freezes arbitration; the ALU resumes because LSU was served last.
        alu_addr = 5'd20; alu_data = 32'h2020;
        lsu_addr = 5'd21; lsu_data = 32'h2121;
        wb_stall = 1'b1;
        repeat (3) begin
            step(ga, gl);
            chk("stall_en", 32'(wr_reg_en), 32'h0);
        end
        wb_stall = 1'b0;
        step(ga, gl);
        chk("resume_addr", 32'(wr_reg_addr), 32'd20);
        alu_valid = 1'b0;
        step(ga, gl);
        lsu_valid = 1'b0;

        // x0 write: accepted, never enabled, never forwarded.
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h1234;
        step(ga, gl);
        chk("x0_ready", 32'(gl), 32'h1);
        lsu_valid = 1'b0;
        #1;
        chk("x0_en", 32'(wr_reg_en), 32'h0);
        chk("x0_hit1", 32'(fwd_hit1), 32'h0);

        // Forwarding of an in-flight write to r7.
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h55;
        step(ga, gl);
        alu_valid = 1'b0;
        fwd_addr1 = 5'd7; fwd_addr2 = 5'd8;
        #1;
        chk("fwd7_hit1", 32'(fwd_hit1), 32'h1);
        chk("fwd7_data1", fwd_data1, 32'h55);
        chk("fwd8_hit2", 32'(fwd_hit2), 32'h0);
        chk("fwd8_data2", fwd_data2, 32'h0);
        fwd_addr1 = 5'd0;
        #1;
        chk("fwd0_hit1", 32'(fwd_hit1), 32'h0);
        step(ga, gl);

        // Randomized traffic; an unserved requester holds its request.
        ga = 1'b1; gl = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid && !ga)) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_addr  = AW'($urandom);
                alu_data  = $urandom;
            end
            if (!(lsu_valid && !gl)) begin
                lsu_valid = ($urandom_range(0, 3) != 0);
                lsu_addr  = AW'($urandom);
                lsu_data  = $urandom;
            end
            wb_stall  = ($urandom_range(0, 4) == 0);
            fwd_addr1 = ($urandom_range(0, 1) == 0) ? m_addr : AW'($urandom);
            fwd_addr2 = ($urandom_range(0, 2) == 0) ? m_addr : AW'($urandom);
            step(ga, gl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
